fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch controller that sequences the program counter and the instruction-memory request port. It issues one fetch at a time and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake. Redirects from execute (branch/jal/jalr targets) flush the buffer and any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, fetch buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address (word aligned)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid (one per granted request, in order)
imem_rdata_i  input  32  fetched instruction
redirect_i  input  1  control-flow redirect from execute
redirect_pc_i  input  32  redirect target
instr_valid_o  output  1  buffer head valid to decode
instr_ready_i  input  1  decode accepts head
instr_o  output  32  buffered instruction
instr_pc_o  output  32  PC of instr_o
pc_o  output  32  next fetch PC

Behaviour:
- Reset (async): state=BOOT; pc_o=RESET_PC; imem_req_o=0; imem_addr_o=RESET_PC; instr_valid_o=0; instr_o=0; instr_pc_o=0; buffer empty; no outstanding fetch.
- States: BOOT, REQ, WAIT, FLUSH. At most one outstanding request.
- BOOT -> REQ unconditionally on the first clk after reset deasserts.
- REQ:
  - imem_req_o = slot_free, where slot_free = (count < BUF_DEPTH).
  - imem_addr_o = pc_o.
  - On req && gnt: pc_o <= pc_o + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), capture the request PC, go to WAIT.
  - Once asserted, req stays high with a stable address until gnt, except on redirect.
- WAIT: imem_req_o=0. On rvalid, push {captured PC, rdata} into the buffer and go to REQ.
- FLUSH: imem_req_o=0. On rvalid, discard the data and go to REQ.
- Redirect has priority over all other events in every state except BOOT, where it is ignored:
  - Buffer cleared; instr_valid_o=0 next cycle; pc_o <= redirect_pc_i.
  - REQ without gnt: stay in REQ, address becomes the new PC next cycle.
  - REQ with gnt same cycle: the granted fetch is stale, go to FLUSH.
  - WAIT without rvalid: go to FLUSH.
  - WAIT with rvalid same cycle: data dropped, go to REQ.
  - FLUSH with rvalid: go to REQ. FLUSH without rvalid: stay in FLUSH.
- Buffer:
  - Registered FIFO; instr_valid_o = (count != 0).
  - Pop when instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle are allowed, and count holds.
  - A pushed entry is visible at the head the cycle after rvalid (1-cycle latency).
  - A pop frees a slot for a request in the next cycle.
  - Push never overflows: a request is only issued with a free slot and no outstanding fetch.
- instr_o and instr_pc_o are held stable while instr_valid_o && !instr_ready_i.
- Fetch throughput is one instruction per two cycles minimum (REQ+gnt, then WAIT+rvalid).
- Reset mid-operation abandons any outstanding fetch. Late rvalid after reset is ignored (state BOOT/REQ).

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined: adds output misalign_o (1 bit, reset 0), which pulses for one cycle when redirect_i has redirect_pc_i[1:0] != 2'b00. The redirect is still taken with bits [1:0] forced to 0.
- Not defined: no port; redirect_pc_i[1:0] is ignored (forced to 0) silently.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt, ready=1 -> req at 0x0, 0x4, 0x8; instr_pc_o sequence 0x0, 0x4, 0x8; pc_o=0xC after third gnt.
- ready=0 with BUF_DEPTH=2 -> exactly two fetches (0x0, 0x4) buffered, req stays 0; ready=1 for one cycle -> req resumes at 0x8 the next cycle; head PC stable while stalled.
- Redirect to 0x100 in WAIT without rvalid -> FLUSH, following rvalid data dropped, next req addr 0x100, buffer empty, no instr_valid_o for old data.
- Redirect to 0x200 in REQ on the same cycle as gnt for 0x10 -> FLUSH; the 0x10 response is discarded; next request addr 0x200.
- pc_o=0xFFFF_FFFC granted -> pc_o becomes 0x0000_0000; async reset asserted mid-WAIT -> all outputs to reset values immediately, the stale rvalid is never pushed.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> misalign_o=1 for one cycle, next request addr 0x100.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
// Sequences the fetch PC and drives a single-outstanding instruction-memory
// request port. Returned instructions and their PCs go into a small FIFO
// that decode drains over a valid/ready handshake. A redirect from execute
// flushes the FIFO and drops any fetch that is still in flight.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add misalign_o, a
// one-cycle pulse flagging a redirect target with nonzero bits [1:0].
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   imem_req_o / imem_addr_o    fetch request and word-aligned address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i/imem_rdata_i  in-order read response
//   redirect_i / redirect_pc_i  control-flow redirect from execute
//   instr_valid_o/instr_ready_i buffer head handshake to decode
//   instr_o / instr_pc_o        buffer head instruction and its PC
//   pc_o                        next fetch PC
//   misalign_o                  (optional) misaligned redirect pulse
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic [31:0] pc_o
);

    localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   mem_instr [BUF_DEPTH];
    logic [31:0]   mem_pc    [BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, flush;
    logic          slot_free, redirect_take;
    logic [31:0]   redirect_pc;

    // Redirects are ignored while booting; targets are forced word aligned.
    assign redirect_take = redirect_i && (state_q != BOOT);
    assign redirect_pc   = {redirect_pc_i[31:2], 2'b00};
    assign slot_free     = (count_q < CW'(BUF_DEPTH));

    // Count cannot grow in REQ (nothing outstanding), so once raised the
    // request holds with a stable address until granted or redirected.
    assign imem_req_o    = (state_q == REQ) && slot_free;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = mem_instr[rd_ptr_q];
    assign instr_pc_o    = mem_pc[rd_ptr_q];
    assign pop           = instr_valid_o && instr_ready_i && !flush;

    // State and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Next-state, PC sequencing, buffer push/flush decisions.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect_take) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                    // A fetch granted alongside the redirect is stale.
                    if (imem_req_o && imem_gnt_i) begin
                        state_d = FLUSH;
                    end
                end else if (imem_req_o && imem_gnt_i) begin
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_take) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid_i ? REQ : FLUSH;
                end else if (imem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            FLUSH: begin
                if (redirect_take) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Fetch buffer FIFO; flush takes priority over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_instr[AW'(i)] <= '0;
                mem_pc[AW'(i)]    <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr_q] <= imem_rdata_i;
                mem_pc[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q            <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // One-cycle flag for a taken redirect whose target was not word aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redirect_take && (redirect_pc_i[1:0] != 2'b00);
        end
    end
`else
    // Low target bits are dropped silently in this build.
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (RESET_PC=0, BUF_DEPTH=2).
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_o    (misalign_o),
`endif
        .pc_o          (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        step();

        // Reset values.
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);

        // Streaming fetch: gnt tied high, rvalid one cycle after gnt.
        do_reset();
        imem_gnt_i    = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_req", imem_req_o, 1);
            chk("t1_addr", imem_addr_o, 32'(4 * i));
            if (i > 0) begin
                chk("t1_head_valid", instr_valid_o, 1);
                chk("t1_head_pc", instr_pc_o, 32'(4 * (i - 1)));
                chk("t1_head_instr", instr_o, 32'hA000_0000 + 32'(i - 1));
            end
            step();
            chk("t1_wait_req", imem_req_o, 0);
            chk("t1_pc", pc_o, 32'(4 * (i + 1)));
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hA000_0000 + 32'(i);
            step();
            imem_rvalid_i = 1'b0;
        end
        chk("t1_last_pc", instr_pc_o, 32'h8);
        chk("t1_last_instr", instr_o, 32'hA000_0002);
        chk("t1_pc_c", pc_o, 32'hC);

        // Decode stalled: buffer fills with two fetches, then one pop.
        do_reset();
        imem_gnt_i = 1'b1;
        chk("t2_req0", imem_req_o, 1);
        chk("t2_addr0", imem_addr_o, 32'h0);
        step();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hB000_0000;
        step();
        imem_rvalid_i = 1'b0;
        chk("t2_valid", instr_valid_o, 1);
        chk("t2_head_pc0", instr_pc_o, 32'h0);
        chk("t2_req1", imem_req_o, 1);
        chk("t2_addr1", imem_addr_o, 32'h4);
        step();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hB000_0001;
        step();
        imem_rvalid_i = 1'b0;
        chk("t2_full_req", imem_req_o, 0);
        chk("t2_stall_pc", instr_pc_o, 32'h0);
        chk("t2_stall_instr", instr_o, 32'hB000_0000);
        step();
        chk("t2_full_req2", imem_req_o, 0);
        chk("t2_stall_pc2", instr_pc_o, 32'h0);
        chk("t2_pc8", pc_o, 32'h8);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        chk("t2_resume_req", imem_req_o, 1);
        chk("t2_resume_addr", imem_addr_o, 32'h8);
        chk("t2_head_pc1", instr_pc_o, 32'h4);
        chk("t2_head_instr1", instr_o, 32'hB000_0001);
        step();

        // Redirect in WAIT without rvalid: FLUSH, late data dropped.
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        chk("t3_flush_req", imem_req_o, 0);
        chk("t3_flush_valid", instr_valid_o, 0);
        chk("t3_pc", pc_o, 32'h100);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_0000;
        step();
        imem_rvalid_i = 1'b0;
        chk("t3_req", imem_req_o, 1);
        chk("t3_addr", imem_addr_o, 32'h100);
        chk("t3_valid", instr_valid_o, 0);
        step();
        chk("t3_valid2", instr_valid_o, 0);

        // Redirect in REQ without gnt, then redirect with gnt for 0x10.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h10;
        step();
        chk("t4_addr10", imem_addr_o, 32'h10);
        chk("t4_req10", imem_req_o, 1);
        redirect_pc_i = 32'h200;
        imem_gnt_i    = 1'b1;
        step();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b0;
        chk("t4_flush_req", imem_req_o, 0);
        chk("t4_pc", pc_o, 32'h200);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0010;
        step();
        imem_rvalid_i = 1'b0;
        chk("t4_req", imem_req_o, 1);
        chk("t4_addr", imem_addr_o, 32'h200);
        chk("t4_valid", instr_valid_o, 0);
        step();
        chk("t4_valid2", instr_valid_o, 0);

        // Redirect in WAIT coinciding with rvalid: data dropped, back to REQ.
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hCAFE_0000;
        step();
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        chk("t5_req", imem_req_o, 1);
        chk("t5_addr", imem_addr_o, 32'h300);
        chk("t5_valid", instr_valid_o, 0);

        // PC wrap at the top of the address space.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        chk("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("t6_wrap", pc_o, 32'h0);
        chk("t6_wait_req", imem_req_o, 0);

        // Async reset mid-WAIT: outputs drop at once, stale rvalid ignored.
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hEEEE_EEEE;
        #2 reset = 1'b1;
        #1;
        chk("t7_req", imem_req_o, 0);
        chk("t7_addr", imem_addr_o, 32'h0);
        chk("t7_pc", pc_o, 32'h0);
        chk("t7_valid", instr_valid_o, 0);
        chk("t7_instr", instr_o, 32'h0);
        chk("t7_instr_pc", instr_pc_o, 32'h0);
        step();
        reset = 1'b0;
        step();
        step();
        imem_rvalid_i = 1'b0;
        chk("t7_late_valid", instr_valid_o, 0);
        chk("t7_late_req", imem_req_o, 1);
        chk("t7_late_addr", imem_addr_o, 32'h0);

        // Misaligned redirect target is word aligned before use.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        step();
        redirect_i = 1'b0;
        chk("t8_addr", imem_addr_o, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t8_misalign_hi", misalign_o, 1);
        step();
        chk("t8_misalign_lo", misalign_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
